// File: rtl/serial_and_sequencer.sv
// serial_and_sequencer: computes a bitwise AND of two WIDTH-bit operands one
// bit at a time. Each cycle it presents one operand bit pair (LSB first) to an
// external combinational AND stage and collects the returned bit into the result.
// Each operation takes WIDTH shift cycles plus one cycle with done high.
module serial_and_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_c,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned        CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and outputs. All outputs depend only on the registered
  // state and shift registers, so they clear as soon as reset is asserted.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    bit_a     = 1'b0;
    bit_b     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        bit_a    = sh_a[0];
        bit_b    = sh_b[0];
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shift registers, bit counter and result assembly. The returned bit
  // enters at the MSB and is shifted down, so after WIDTH shifts the bit taken
  // in shift k ends up at position k. The counter saturates at its last value
  // instead of wrapping back to zero on the final shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (load) begin
      sh_a   <= op_a;
      sh_b   <= op_b;
      cnt    <= '0;
      result <= '0;
    end else if (shift_en) begin
      sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
      result <= {bit_c, result[WIDTH-1:1]};
      if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/serial_and_sequencer.md
SERIAL_AND_SEQUENCER -- requirements
Module: serial_and_sequencer

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand and result width in bits (legal range 2..32).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op_a, input, WIDTH bits: first operand.
REQ-006 The block SHALL have port op_b, input, WIDTH bits: second operand.
REQ-007 The block SHALL have port bit_a, output, 1 bit: serial operand A bit, driven to the downstream 2-input AND stage.
REQ-008 The block SHALL have port bit_b, output, 1 bit: serial operand B bit, driven to the AND stage.
REQ-009 The block SHALL have port bit_c, input, 1 bit: combinational result returned by the AND stage in the same cycle.
REQ-010 The block SHALL have port result, output, WIDTH bits: assembled bitwise result.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE, when start=1 at a rising edge, the block SHALL latch op_a and op_b into shift registers sh_a and sh_b, clear result to 0, clear the bit counter to 0, and go to SHIFT.
REQ-015 In SHIFT, bit_a SHALL equal sh_a[0] and bit_b SHALL equal sh_b[0]; in IDLE and DONE, bit_a and bit_b SHALL be 0.
REQ-016 At each SHIFT edge, the block SHALL perform result <= {bit_c, result[WIDTH-1:1]}, shift sh_a and sh_b right by 1 with zero fill, and increment the counter.
REQ-017 After exactly WIDTH SHIFT edges (counter = WIDTH-1 at the edge), the block SHALL go to DONE, leaving result[i] = op_a[i] & op_b[i] for every bit i.
REQ-018 The bit counter SHALL be clog2(WIDTH) bits wide, SHALL NOT wrap within an operation, and SHALL be cleared on entry to SHIFT.
REQ-019 DONE SHALL last exactly one cycle with done=1, followed by an unconditional transition to IDLE.
REQ-020 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-021 Latency: for start sampled at edge E0, done SHALL be high between edges E(WIDTH) and E(WIDTH+1), and busy SHALL fall at E(WIDTH+1).
REQ-022 start in SHIFT or DONE SHALL be ignored; changes to op_a and op_b after the accepting edge SHALL NOT affect the operation in progress.
REQ-023 result SHALL hold its final value from DONE until the next accepted start.
REQ-024 With start held high continuously, operations SHALL repeat back-to-back, with one accepted every WIDTH+2 cycles.
REQ-025 bit_c SHALL be sampled only in SHIFT; its value in IDLE and DONE SHALL have no effect.

Reset
REQ-026 When rst_n=0, regardless of clk or state, the block SHALL immediately force state=IDLE, sh_a=0, sh_b=0, counter=0, result=0, busy=0, done=0, bit_a=0 and bit_b=0.
REQ-027 Reset asserted mid-operation SHALL abort that operation with no done pulse; the first start after rst_n rises SHALL be handled as from power-up.

Verification (WIDTH=8, bench drives bit_c = bit_a & bit_b)
REQ-028 The bench SHALL check: op_a=0xF0, op_b=0x3C, start pulsed at E0 -> bit_a sequence 0,0,0,0,1,1,1,1, done=1 after E8 only, result=0x30, busy=0 after E9.
REQ-029 The bench SHALL check: op_a=0xFF, op_b=0xFF -> result=0xFF; op_a=0xAA, op_b=0x55 -> result=0x00.
REQ-030 The bench SHALL check: start held high with op_a=0x0F, op_b=0xFF constant -> done pulses exactly 10 cycles apart, each with result=0x0F.
REQ-031 The bench SHALL check: start pulsed at E3 with op_a=0x00 during an operation on 0xC3/0x81 -> operation unaffected, result=0x81, no extra done.
REQ-032 The bench SHALL check: rst_n driven low between edges E4 and E5 of an operation -> all outputs 0 without waiting for a clock edge, no done pulse; a new start on 0x12/0x1F after release -> result=0x12.
REQ-033 The bench SHALL check: bit_c forced to 1 while in IDLE -> result and state unchanged.
